// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: elastic FWFT buffer between the RX width converter and an
// AXI4-Stream consumer. The upstream side cannot be stalled, so beats that do
// not fit are dropped (rest of the packet included) and a sticky overflow flag
// is raised. A hysteretic pause request lets the TX side throttle the far end.
module rx_frame_buffer #(
   parameter int PAYLOAD_WIDTH = 240,
   parameter int DEPTH         = 32,
   parameter int PAUSE_THRESH  = 24,
   parameter int RESUME_THRESH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [PAYLOAD_WIDTH-1:0]      int_tdata,
   input  logic [PAYLOAD_WIDTH/8-1:0]    int_tkeep,
   input  logic                          int_tlast,
   input  logic                          int_tvalid,
   output logic [PAYLOAD_WIDTH-1:0]      m_axis_tdata,
   output logic [PAYLOAD_WIDTH/8-1:0]    m_axis_tkeep,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [$clog2(DEPTH):0]        occupancy,
   output logic                          pause_req,
   output logic                          overflow,
   input  logic                          overflow_clr
);

   localparam int KW = PAYLOAD_WIDTH / 8;
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = PAYLOAD_WIDTH + KW + 1;

   localparam logic [PW-1:0] OCC_FULL  = PW'(DEPTH);
   localparam logic [PW-1:0] PAUSE_C   = PW'(PAUSE_THRESH);
   localparam logic [PW-1:0] RESUME_C  = PW'(RESUME_THRESH);
   localparam logic [PW-1:0] PTR_ZERO  = '0;

   typedef enum logic {PASS = 1'b0, DROP = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             pause_q, pause_d;
   logic             ovf_q, ovf_d;
   logic [EW-1:0]    mem_q [DEPTH];

   logic [PW-1:0]    occ_q, occ_d;
   logic             full, empty;
   logic             wr_en, rd_en, drop_full;

   // Pointers wrap modulo 2*DEPTH, so their difference is the exact entry count.
   assign occ_q = wr_ptr_q - rd_ptr_q;
   assign occ_d = wr_ptr_d - rd_ptr_d;
   assign full  = (occ_q == OCC_FULL);
   assign empty = (occ_q == PTR_ZERO);
   assign rd_en = !empty && m_axis_tready;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= PASS;
      else        state_q <= state_d;
   end

   // FSM next state: a non-last beat lost to full enters DROP until tlast
   always_comb begin
      state_d = state_q;
      case (state_q)
         PASS: if (int_tvalid && full && !int_tlast) state_d = DROP;
         DROP: if (int_tvalid && int_tlast)          state_d = PASS;
         default:                                    state_d = PASS;
      endcase
   end

   // FSM outputs: full is judged on pre-edge occupancy, so a same-cycle read
   // never makes room for this cycle's write
   always_comb begin
      wr_en     = 1'b0;
      drop_full = 1'b0;
      if (state_q == PASS && int_tvalid) begin
         wr_en     = !full;
         drop_full = full;
      end
   end

   // Next pointer, pause and overflow values
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
      pause_d  = pause_q;
      if (occ_d >= PAUSE_C)       pause_d = 1'b1;
      else if (occ_d <= RESUME_C) pause_d = 1'b0;
      ovf_d = ovf_q;
      if (drop_full)         ovf_d = 1'b1;
      else if (overflow_clr) ovf_d = 1'b0;
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         pause_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pause_q  <= pause_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array; contents need no reset since empty masks them
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {int_tlast, int_tkeep, int_tdata};
   end

   assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem_q[rd_ptr_q[AW-1:0]];
   assign m_axis_tvalid = !empty;
   assign occupancy     = occ_q;
   assign pause_req     = pause_q;
   assign overflow      = ovf_q;

endmodule

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
- Elastic buffer directly downstream of the RX width converter.
- Accepts the converter's non-backpressurable internal stream (int_tdata/int_tkeep/int_tlast/int_tvalid) and presents a standard AXI4-Stream master with tready.
- Raises a hysteretic pause request so the TX side can send flow-control to the far end before the buffer overflows.
- On overflow, drops the remainder of the packet in progress and flags the event.

Parameters:
- PAYLOAD_WIDTH, 240, data width in bits; multiple of 8.
- DEPTH, 32, FIFO entries; power of 2, >= 8.
- PAUSE_THRESH, 24, occupancy at or above which pause_req asserts; < DEPTH.
- RESUME_THRESH, 16, occupancy at or below which pause_req deasserts; < PAUSE_THRESH.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- int_tdata  in  PAYLOAD_WIDTH  payload from width converter.
- int_tkeep  in  PAYLOAD_WIDTH/8  byte enables.
- int_tlast  in  1  end of packet.
- int_tvalid  in  1  beat valid; single-cycle qualifier, no backpressure possible.
- m_axis_tdata  out  PAYLOAD_WIDTH  AXIS data.
- m_axis_tkeep  out  PAYLOAD_WIDTH/8  AXIS keep.
- m_axis_tlast  out  1  AXIS last.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- occupancy  out  $clog2(DEPTH)+1  stored entry count.
- pause_req  out  1  flow-control request to TX.
- overflow  out  1  sticky overflow flag.
- overflow_clr  in  1  clears overflow; synchronous, single-cycle.

Behaviour:
- Reset (rst_n low, async): pointers = 0, occupancy = 0, m_axis_tvalid = 0, pause_req = 0, overflow = 0, state = PASS. m_axis_tdata/tkeep/tlast are don't-care while tvalid = 0.
- Storage: circular RAM of DEPTH x (PAYLOAD_WIDTH + PAYLOAD_WIDTH/8 + 1). Read and write pointers are $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH. full = (occupancy == DEPTH); empty = (occupancy == 0).
- Output is first-word-fall-through.
  - m_axis_tvalid = !empty; m_axis_t* show the head entry.
  - Latency: a beat written at edge N is visible on m_axis with tvalid = 1 in the cycle after edge N. There is no same-cycle bypass.
- Read: occurs at an edge when m_axis_tvalid && m_axis_tready; rd_ptr increments.
- Data, keep and last must stay stable while tvalid = 1 and tready = 0.
- Write acceptance: a beat is accepted when int_tvalid = 1, state = PASS and !full. full is evaluated on pre-edge occupancy. A simultaneous read while full does NOT free space for that cycle's write.
- Occupancy update: +1 on write only, -1 on read only, unchanged on both or neither.
- FSM, 2 states:
  - PASS -> DROP: int_tvalid && full && !int_tlast. The beat is discarded and overflow is set.
  - PASS stays PASS with overflow set: int_tvalid && full && int_tlast. The beat is discarded; there is nothing further to drop.
  - DROP: every int_tvalid beat is discarded, regardless of free space.
  - DROP -> PASS: int_tvalid && int_tlast; that beat is discarded too.
  - Next packet after returning to PASS is accepted normally.
  - Consequence: downstream may see a packet without tlast. This is accepted; overflow reports it.
- overflow: sticky.
  - Set on any discarded beat caused by full.
  - Cleared by overflow_clr. If set and clear occur in the same cycle, set wins.
- pause_req: registered, hysteretic, computed from post-edge occupancy.
  - Asserts when occupancy >= PAUSE_THRESH.
  - Deasserts when occupancy <= RESUME_THRESH.
  - Holds its value between the two thresholds.
- int_tvalid = 0 beats are ignored. int_tdata/int_tkeep/int_tlast are don't-care when int_tvalid = 0.
- Mid-operation reset: all stored data is lost and outputs return to reset values immediately (asynchronous). Deassertion of rst_n is synchronized externally.

Test Plan:
- Passthrough: tready = 1; 4-beat packet (tkeep all ones, last beat tkeep = 30'h3FFF0000 with tlast) -> identical 4 beats on m_axis, each 1 cycle after input; occupancy never exceeds 1.
- Backpressure/stability: tready = 0 for 10 cycles while 5 beats arrive -> occupancy = 5, head beat stable; tready = 1 -> 5 beats drain in order on consecutive cycles, occupancy reaches 0.
- Hysteresis: tready = 0, write 24 beats -> pause_req rises the cycle after the 24th write. Drain to 17 -> still 1. Drain to 16 -> 0.
- Overflow drop: tready = 0, fill 32 beats, then send a 3-beat packet -> all 3 beats dropped, overflow = 1, occupancy = 32. Next packet after draining 5 entries is stored intact. overflow_clr -> overflow = 0.
- Full with simultaneous read: occupancy = 32, tready = 1 and int_tvalid = 1 in the same cycle -> the write is dropped, occupancy = 31, overflow = 1.
- Async reset: assert rst_n low mid-drain with occupancy = 12 -> m_axis_tvalid, occupancy, pause_req and overflow go to 0 without waiting for a clock edge.
